imem_responder: RTL and testbench

Instruction-memory responder for the mips_16 core's fetch and instruction-rewrite port. It answers the core's `pc` with a 16-bit `instruction` in the same cycle. It accepts randomized instruction write-backs (`inst_write_en` / `inst_write_data`) at the current `pc` through a one-entry write buffer with fetch bypass. It boot-loads the program over a valid/ready port and holds the core in reset until loading completes.

---
 rtl/imem_responder_pkg.sv | 12 +
 rtl/imem_array.sv | 22 ++
 rtl/imem_responder.sv | 123 ++++++++++++
 tb/tb_imem_responder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: shared parameters and FSM state encoding for the instruction-memory responder
package imem_responder_pkg;

    localparam int PC_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/imem_array.sv
// imem_array: 2^AW x 16 instruction storage, one asynchronous read port and one synchronous write port
module imem_array #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [15:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [15:0]   o_rdata
);

    logic [15:0] r_mem [0:(1<<AW)-1];

    // single write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_responder.sv
// imem_responder: boot loader, one-entry rewrite buffer with fetch bypass, and core hold control
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] pc,
    output logic [15:0]         instruction,
    input  logic                inst_write_en,
    input  logic [15:0]         inst_write_data,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [PC_WIDTH-1:0] load_addr,
    input  logic [15:0]         load_data,
    input  logic                load_last,
    input  logic                reload,
    output logic                core_hold,
    output logic [PC_WIDTH:0]   load_count,
    output logic [15:0]         rewrite_count
);

    localparam logic [PC_WIDTH:0] LC_MAX = {1'b1, {PC_WIDTH{1'b0}}};

    state_t              r_state;
    state_t              w_next;
    logic                r_buf_valid;
    logic [PC_WIDTH-1:0] r_buf_addr;
    logic [15:0]         r_buf_data;
    logic [PC_WIDTH:0]   r_load_count;
    logic [15:0]         r_rewrite_count;
    logic                w_load_fire;
    logic                w_run_write;
    logic                w_commit;
    logic                w_clear_count;
    logic                w_we;
    logic [PC_WIDTH-1:0] w_waddr;
    logic [15:0]         w_wdata;
    logic [15:0]         w_rdata;

    // state register; reset drops straight back to LOAD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_LOAD;
        else      r_state <= w_next;
    end

    // next state and per-state strobes; DRAIN always empties the buffer in its single cycle
    always_comb begin
        w_next        = r_state;
        load_ready    = 1'b0;
        core_hold     = 1'b1;
        w_load_fire   = 1'b0;
        w_run_write   = 1'b0;
        w_commit      = 1'b0;
        w_clear_count = 1'b0;
        case (r_state)
            S_LOAD: begin
                load_ready  = 1'b1;
                w_load_fire = load_valid;
                if (load_valid && load_last) w_next = S_RUN;
            end
            S_RUN: begin
                core_hold   = 1'b0;
                w_run_write = inst_write_en;
                w_commit    = r_buf_valid;
                if (reload) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_commit      = r_buf_valid;
                w_clear_count = 1'b1;
                w_next        = S_LOAD;
            end
            default: w_next = S_LOAD;
        endcase
    end

    // loader and buffer commit live in disjoint states, so they share the one write port
    assign w_we    = w_load_fire | w_commit;
    assign w_waddr = w_load_fire ? load_addr : r_buf_addr;
    assign w_wdata = w_load_fire ? load_data : r_buf_data;

    imem_array #(.AW(PC_WIDTH)) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (pc),
        .o_rdata (w_rdata)
    );

    // write buffer: a valid entry is always committed on the next edge, so capture never overflows
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
        end else begin
            r_buf_valid <= w_run_write;
            if (w_run_write) begin
                r_buf_addr <= pc;
                r_buf_data <= inst_write_data;
            end
        end
    end

    // saturating counters for loaded words and accepted rewrites
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_load_count    <= '0;
            r_rewrite_count <= '0;
        end else begin
            if (w_clear_count)                                r_load_count <= '0;
            else if (w_load_fire && r_load_count != LC_MAX)   r_load_count <= r_load_count + 1'b1;
            if (w_run_write && r_rewrite_count != 16'hFFFF)   r_rewrite_count <= r_rewrite_count + 1'b1;
        end
    end

    assign instruction   = (r_buf_valid && r_buf_addr == pc) ? r_buf_data : w_rdata;
    assign load_count    = r_load_count;
    assign rewrite_count = r_rewrite_count;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: randomized scoreboard bench against a flat memory/counter reference model
module tb_imem_responder;

    localparam int PW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 0;
    logic          rst = 1;
    logic [PW-1:0] pc = '0;
    logic          inst_write_en = 0;
    logic [15:0]   inst_write_data = '0;
    logic          load_valid = 0;
    logic [PW-1:0] load_addr = '0;
    logic [15:0]   load_data = '0;
    logic          load_last = 0;
    logic          reload = 0;
    logic [15:0]   instruction;
    logic          load_ready;
    logic          core_hold;
    logic [PW:0]   load_count;
    logic [15:0]   rewrite_count;

    imem_responder #(.PC_WIDTH(PW)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .instruction     (instruction),
        .inst_write_en   (inst_write_en),
        .inst_write_data (inst_write_data),
        .load_valid      (load_valid),
        .load_ready      (load_ready),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .load_last       (load_last),
        .reload          (reload),
        .core_hold       (core_hold),
        .load_count      (load_count),
        .rewrite_count   (rewrite_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t  expq[$];
    int    n_chk = 0;
    int    n_fail = 0;
    string names[5] = '{"instruction", "core_hold", "load_ready", "load_count", "rewrite_count"};

    logic [15:0] m_mem[DEPTH];
    bit          m_known[DEPTH];
    int          m_lcnt = 0;
    int          m_rcnt = 0;
    bit          m_run = 0;

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (expq.size() > 0) begin
            e = expq.pop_front();
            case (e.kind)
                0:       act = {16'h0, instruction};
                1:       act = {31'h0, core_hold};
                2:       act = {31'h0, load_ready};
                3:       act = {23'h0, load_count};
                default: act = {16'h0, rewrite_count};
            endcase
            n_chk++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h (pc=%0d t=%0t)", names[e.kind], act, e.exp, pc, $time);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(int k, int v);
        expq.push_back(exp_t'{k, 32'(v)});
    endtask

    task automatic chk_fetch(int a);
        pc = PW'(a);
        if (m_known[a]) chk(0, int'(m_mem[a]));
    endtask

    task automatic load(int a, int d, bit last);
        chk(2, 1);
        load_valid = 1;
        load_addr  = PW'(a);
        load_data  = 16'(d);
        load_last  = last;
        tick();
        load_valid = 0;
        load_last  = 0;
        m_mem[a]   = 16'(d);
        m_known[a] = 1;
        if (m_lcnt < DEPTH) m_lcnt++;
        if (last) m_run = 1;
    endtask

    task automatic wr(int a, int d, bit rl);
        pc              = PW'(a);
        inst_write_en   = 1;
        inst_write_data = 16'(d);
        reload          = rl;
        if (m_known[a]) chk(0, int'(m_mem[a]));
        tick();
        inst_write_en = 0;
        reload        = 0;
        if (m_run) begin
            m_mem[a]   = 16'(d);
            m_known[a] = 1;
            if (m_rcnt < 65535) m_rcnt++;
            if (rl) m_run = 0;
        end
    endtask

    task automatic do_reset();
        rst = 0;
        #1;
        m_lcnt = 0;
        m_rcnt = 0;
        m_run  = 0;
        chk(1, 1);
        chk(2, 1);
        chk(3, 0);
        chk(4, 0);
    endtask

    task automatic go_reload();
        reload = 1;
        tick();
        reload = 0;
        m_run  = 0;
        chk(1, 1);
        chk(2, 0);
        tick();
        m_lcnt = 0;
        chk(1, 1);
        chk(2, 1);
        chk(3, 0);
    endtask

    task automatic run_random(int n, int amax);
        int a;
        for (int i = 0; i < n; i++) begin
            a = $urandom_range(0, amax);
            chk(1, 0);
            chk(4, m_rcnt);
            if ($urandom_range(0, 2) == 0) begin
                chk_fetch(a);
                tick();
            end else begin
                wr(a, int'($urandom_range(0, 65535)), 0);
            end
        end
    endtask

    initial begin
        logic [15:0] saved;
        bit          saved_k;
        #2;
        do_reset();
        tick();
        tick();
        rst = 1;
        tick();

        load(0, 'h1111, 0);
        load(1, 'h2222, 0);
        load(2, 'h3333, 1);
        n_chk++;
        if (load_count !== 9'd3) begin
            n_fail++;
            $display("FAIL boot load_count: got %0d expected 3", load_count);
        end
        n_chk++;
        if (core_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL boot core_hold: got %0b expected 0", core_hold);
        end
        chk(3, 3);
        chk(1, 0);
        chk(2, 0);
        chk_fetch(1);
        tick();

        wr(1, 'hABCD, 0);
        chk_fetch(1);
        chk(4, 1);
        tick();
        chk_fetch(1);
        tick();

        wr(2, 'h0F0F, 0);
        wr(3, 'hF0F0, 0);
        tick();
        chk_fetch(2);
        tick();
        chk_fetch(3);
        chk(4, 3);
        tick();

        run_random(300, 15);

        wr(0, 'h5555, 1);
        chk(1, 1);
        chk(2, 0);
        tick();
        m_lcnt = 0;
        chk(1, 1);
        chk(2, 1);
        chk(3, 0);
        chk_fetch(0);
        chk(4, m_rcnt);
        wr(0, 'h1234, 0);
        chk_fetch(0);
        chk(4, m_rcnt);
        tick();

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) load($urandom_range(0, 7), int'($urandom_range(0, 65535)), 0);
            else tick();
            chk(3, m_lcnt);
        end
        load(255, 'hBEEF, 1);
        chk(1, 0);
        chk(3, m_lcnt);
        for (int a = 0; a < 16; a++) begin
            chk_fetch(a);
            tick();
        end
        chk_fetch(255);
        tick();

        saved   = m_mem[2];
        saved_k = m_known[2];
        wr(2, 'h7777, 1);
        m_mem[2]   = saved;
        m_known[2] = saved_k;
        chk(1, 1);
        do_reset();
        tick();
        rst = 1;
        chk_fetch(2);
        tick();

        load(10, 'hAAAA, 0);
        do_reset();
        n_chk++;
        if (core_hold !== 1'b1 || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid-load reset: core_hold=%0b load_ready=%0b", core_hold, load_ready);
        end
        n_chk++;
        if (load_count !== 9'd0) begin
            n_fail++;
            $display("FAIL mid-load reset load_count: got %0d expected 0", load_count);
        end
        tick();
        rst = 1;
        wr(3, 'h9999, 0);
        n_chk++;
        if (rewrite_count !== 16'd0) begin
            n_fail++;
            $display("FAIL load-state rewrite_count: got %0d expected 0", rewrite_count);
        end
        chk(4, 0);
        chk(3, 0);
        chk_fetch(3);
        tick();
        load(4, 'h4444, 0);
        load(5, 'h5A5A, 0);
        load(6, 'h6666, 1);
        chk(3, 3);
        chk(1, 0);
        chk_fetch(10);
        tick();

        go_reload();
        for (int i = 0; i < 258; i++) load(i % DEPTH, int'($urandom_range(0, 65535)), i == 257);
        chk(3, DEPTH);
        chk(1, 0);
        tick();
        run_random(150, DEPTH - 1);

        tick();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
